// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: converts one register read/write request into the
// byte-level START / WRITE / READ / STOP command stream for a bit-level I2C
// engine. A NACK on any written byte aborts to STOP. The whole transaction is
// then retried up to MAX_RETRY extra times before an error response is given.
module i2c_reg_sequencer #(
    parameter int MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_data,
    output logic       cmd_nack,
    input  logic       done_valid,
    input  logic       done_ack,
    input  logic [7:0] done_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        START,
        DEVW,
        REG,
        WDATA,
        RSTART,
        DEVR,
        RDATA,
        STOP,
        RESP
    } state_t;

    state_t               state_reg;
    state_t               state_next;

    // Captured request
    logic                 rw_reg;
    logic [6:0]           dev_reg;
    logic [7:0]           reg_addr_reg;
    logic [7:0]           wdata_reg;
    logic [7:0]           rdata_reg;

    // Transaction bookkeeping
    logic [RETRY_W-1:0]   retry_reg;
    logic                 nack_pending_reg;
    logic                 waiting_reg;

    // Registered outputs
    logic                 req_ready_reg;
    logic                 cmd_valid_reg;
    logic [1:0]           cmd_op_reg;
    logic [7:0]           cmd_data_reg;
    logic                 cmd_nack_reg;
    logic                 rsp_valid_reg;
    logic [7:0]           rsp_rdata_reg;
    logic                 rsp_err_reg;

    // Decoded transition side effects
    logic                 advance;
    logic                 set_nack;
    logic                 retry_inc;
    logic                 give_up;

    // Command that belongs to the state being entered
    logic                 has_cmd_next;
    logic [1:0]           cmd_op_next;
    logic [7:0]           cmd_data_next;
    logic                 cmd_nack_next;

    assign req_ready = req_ready_reg;
    assign cmd_valid = cmd_valid_reg;
    assign cmd_op    = cmd_op_reg;
    assign cmd_data  = cmd_data_reg;
    assign cmd_nack  = cmd_nack_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

    // A completion only counts when a command has actually been accepted.
    assign advance = waiting_reg & done_valid;

    // Next-state decode: every command state leaves only on its own completion.
    always_comb begin
        state_next = state_reg;
        set_nack   = 1'b0;
        retry_inc  = 1'b0;
        give_up    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = START;
                end
            end
            START: begin
                if (advance) begin
                    state_next = DEVW;
                end
            end
            DEVW: begin
                if (advance) begin
                    if (done_ack) begin
                        state_next = REG;
                    end else begin
                        state_next = STOP;
                        set_nack   = 1'b1;
                    end
                end
            end
            REG: begin
                if (advance) begin
                    if (!done_ack) begin
                        state_next = STOP;
                        set_nack   = 1'b1;
                    end else if (rw_reg) begin
                        state_next = RSTART;
                    end else begin
                        state_next = WDATA;
                    end
                end
            end
            WDATA: begin
                if (advance) begin
                    state_next = STOP;
                    set_nack   = ~done_ack;
                end
            end
            RSTART: begin
                if (advance) begin
                    state_next = DEVR;
                end
            end
            DEVR: begin
                if (advance) begin
                    if (done_ack) begin
                        state_next = RDATA;
                    end else begin
                        state_next = STOP;
                        set_nack   = 1'b1;
                    end
                end
            end
            RDATA: begin
                if (advance) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (advance) begin
                    if (nack_pending_reg && (retry_reg < RETRY_LIMIT)) begin
                        state_next = START;
                        retry_inc  = 1'b1;
                    end else begin
                        state_next = RESP;
                        give_up    = nack_pending_reg;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command payload for the state about to be entered.
    always_comb begin
        has_cmd_next  = 1'b0;
        cmd_op_next   = OP_START;
        cmd_data_next = 8'h00;
        cmd_nack_next = 1'b0;
        case (state_next)
            START, RSTART: begin
                has_cmd_next = 1'b1;
            end
            DEVW: begin
                has_cmd_next  = 1'b1;
                cmd_op_next   = OP_WRITE;
                cmd_data_next = {dev_reg, 1'b0};
            end
            REG: begin
                has_cmd_next  = 1'b1;
                cmd_op_next   = OP_WRITE;
                cmd_data_next = reg_addr_reg;
            end
            WDATA: begin
                has_cmd_next  = 1'b1;
                cmd_op_next   = OP_WRITE;
                cmd_data_next = wdata_reg;
            end
            DEVR: begin
                has_cmd_next  = 1'b1;
                cmd_op_next   = OP_WRITE;
                cmd_data_next = {dev_reg, 1'b1};
            end
            RDATA: begin
                has_cmd_next  = 1'b1;
                cmd_op_next   = OP_READ;
                cmd_nack_next = 1'b1;
            end
            STOP: begin
                has_cmd_next = 1'b1;
                cmd_op_next  = OP_STOP;
            end
            default: begin
                has_cmd_next = 1'b0;
            end
        endcase
    end

    // Sequencer state, request capture, command handshake and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            rw_reg           <= 1'b0;
            dev_reg          <= 7'h00;
            reg_addr_reg     <= 8'h00;
            wdata_reg        <= 8'h00;
            rdata_reg        <= 8'h00;
            retry_reg        <= '0;
            nack_pending_reg <= 1'b0;
            waiting_reg      <= 1'b0;
            req_ready_reg    <= 1'b1;
            cmd_valid_reg    <= 1'b0;
            cmd_op_reg       <= OP_START;
            cmd_data_reg     <= 8'h00;
            cmd_nack_reg     <= 1'b0;
            rsp_valid_reg    <= 1'b0;
            rsp_rdata_reg    <= 8'h00;
            rsp_err_reg      <= 1'b0;
        end else begin
            if (state_reg == IDLE && req_valid) begin
                rw_reg           <= req_rw;
                dev_reg          <= req_dev;
                reg_addr_reg     <= req_reg;
                wdata_reg        <= req_wdata;
                rdata_reg        <= 8'h00;
                retry_reg        <= '0;
                nack_pending_reg <= 1'b0;
            end

            if (set_nack) begin
                nack_pending_reg <= 1'b1;
            end
            if (retry_inc) begin
                retry_reg        <= retry_reg + RETRY_W'(1);
                nack_pending_reg <= 1'b0;
            end

            if (state_reg == RDATA && advance) begin
                rdata_reg <= done_data;
            end

            state_reg     <= state_next;
            req_ready_reg <= (state_next == IDLE);
            rsp_valid_reg <= (state_next == RESP);
            rsp_err_reg   <= give_up;
            rsp_rdata_reg <= (state_next == RESP && !give_up) ? rdata_reg : 8'h00;

            // Every state change presents the new state's command at once;
            // otherwise the held command drops after acceptance and waits.
            if (state_next != state_reg) begin
                waiting_reg   <= 1'b0;
                cmd_valid_reg <= has_cmd_next;
                cmd_op_reg    <= cmd_op_next;
                cmd_data_reg  <= cmd_data_next;
                cmd_nack_reg  <= cmd_nack_next;
            end else if (cmd_valid_reg && cmd_ready) begin
                cmd_valid_reg <= 1'b0;
                waiting_reg   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: drives register requests into i2c_reg_sequencer,
// emulates the bit-level engine (stalls, latency, NACK plans, stray
// completions) and compares the command stream and response with a
// transaction-level model of the expected I2C sequence.
module tb_i2c_reg_sequencer;

    localparam int MAXR = 2;
    localparam logic [1:0] OP_S = 2'b00;
    localparam logic [1:0] OP_W = 2'b01;
    localparam logic [1:0] OP_R = 2'b10;
    localparam logic [1:0] OP_P = 2'b11;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_nack;
    logic       done_valid;
    logic       done_ack;
    logic [7:0] done_data;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    i2c_reg_sequencer #(.MAX_RETRY(MAXR)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_dev    (req_dev),
        .req_reg    (req_reg),
        .req_wdata  (req_wdata),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_nack   (cmd_nack),
        .done_valid (done_valid),
        .done_ack   (done_ack),
        .done_data  (done_data),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Observed traffic
    logic [10:0] cmd_log[$];
    logic [8:0]  rsp_q[$];

    // Engine behaviour knobs
    int          nack_pos[8];
    int          attempt;
    int          wi;
    logic [7:0]  rd_byte;
    bit          rand_stall;
    bit          rand_spur;
    bit          hold_read;
    bit          stall_used;
    int          force_stall_byte;
    int          txn_id;
    int          rp[3];

    // Engine internal state
    bit          pending;
    int          cnt;
    logic [1:0]  pend_op;
    logic        pend_ack;
    logic [7:0]  pend_data;
    int          stall_left;
    bit          gap_chk;
    bit          hold_chk;
    logic [10:0] held_cmd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Response monitor
    initial begin
        forever begin
            @(negedge clk);
            if (reset && rsp_valid) begin
                rsp_q.push_back({rsp_err, rsp_rdata});
            end
        end
    end

    // Bit-level engine emulation: accepts commands, answers after 1..3 cycles.
    initial begin
        cmd_ready  = 1'b0;
        done_valid = 1'b0;
        done_ack   = 1'b0;
        done_data  = 8'h00;
        pending    = 0;
        cnt        = 0;
        stall_left = 0;
        gap_chk    = 0;
        hold_chk   = 0;
        held_cmd   = '0;
        pend_op    = OP_S;
        pend_ack   = 1'b0;
        pend_data  = 8'h00;
        forever begin
            @(negedge clk);
            done_valid = 1'b0;
            done_ack   = 1'b0;
            done_data  = 8'h00;
            if (gap_chk && reset) begin
                check("no_gap_after_done", 32'(cmd_valid), 32'd1);
            end
            gap_chk = 0;
            if (hold_chk && reset) begin
                check("cmd_hold", 32'({cmd_valid, cmd_op, cmd_data, cmd_nack}), 32'({1'b1, held_cmd}));
            end
            hold_chk = 0;
            if (!reset) begin
                pending    = 0;
                stall_left = 0;
                cmd_ready  = 1'b0;
            end else begin
                if (pending) begin
                    if (cnt > 0) cnt--;
                    if (cnt == 0) begin
                        done_valid = 1'b1;
                        done_ack   = pend_ack;
                        done_data  = pend_data;
                        pending    = 0;
                        gap_chk    = (pend_op != OP_P);
                    end
                end else if (rand_spur && $urandom_range(0, 7) == 0) begin
                    done_valid = 1'b1;
                    done_ack   = 1'($urandom);
                    done_data  = 8'($urandom);
                end
                if (cmd_valid && force_stall_byte >= 0 && cmd_op == OP_W &&
                    cmd_data == force_stall_byte[7:0] && !stall_used) begin
                    stall_left = 4;
                    stall_used = 1;
                end
                if (stall_left > 0) begin
                    cmd_ready = 1'b0;
                    if (stall_left == 2) begin
                        done_valid = 1'b1;
                        done_ack   = 1'b0;
                    end
                    stall_left--;
                end else if (rand_stall) begin
                    cmd_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    cmd_ready = 1'b1;
                end
                if (cmd_valid && cmd_ready) begin
                    pend_ack  = 1'b1;
                    pend_data = 8'h00;
                    if (cmd_op == OP_W) begin
                        pend_ack = (nack_pos[attempt] != wi);
                        wi++;
                    end
                    if (cmd_op == OP_R) pend_data = rd_byte;
                    if (cmd_op == OP_P) begin
                        attempt++;
                        wi = 0;
                    end
                    cmd_log.push_back({cmd_op, cmd_data, cmd_nack});
                    pending = 1;
                    pend_op = cmd_op;
                    cnt = (hold_read && cmd_op == OP_R) ? 100000 : int'($urandom_range(1, 3));
                end else if (cmd_valid) begin
                    hold_chk = 1;
                    held_cmd = {cmd_op, cmd_data, cmd_nack};
                end
            end
        end
    end

    // Build the expected command list, run one request, compare everything.
    task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] rb,
                           input int np0, input int np1, input int np2);
        logic [10:0] seq[$];
        logic [10:0] exp_q[$];
        logic [7:0]  exp_rd;
        logic        exp_err;
        bit          fin;
        bit          nk;
        int          w;
        int          g;
        int          n;
        exp_rd  = 8'h00;
        exp_err = 1'b0;
        fin     = 0;
        for (int i = 0; i < 8; i++) nack_pos[i] = -1;
        nack_pos[0] = np0;
        nack_pos[1] = np1;
        nack_pos[2] = np2;

        seq.push_back({OP_W, dev, 1'b0, 1'b0});
        seq.push_back({OP_W, rg, 1'b0});
        if (rw) begin
            seq.push_back({OP_S, 8'h00, 1'b0});
            seq.push_back({OP_W, dev, 1'b1, 1'b0});
            seq.push_back({OP_R, 8'h00, 1'b1});
        end else begin
            seq.push_back({OP_W, wd, 1'b0});
        end
        for (int a = 0; a <= MAXR && !fin; a++) begin
            exp_q.push_back({OP_S, 8'h00, 1'b0});
            w  = 0;
            nk = 0;
            for (int i = 0; i < seq.size(); i++) begin
                exp_q.push_back(seq[i]);
                if (seq[i][10:9] == OP_W) begin
                    if (nack_pos[a] == w) begin
                        nk = 1;
                        break;
                    end
                    w++;
                end
            end
            exp_q.push_back({OP_P, 8'h00, 1'b0});
            if (!nk) begin
                fin     = 1;
                exp_err = 1'b0;
                exp_rd  = rw ? rb : 8'h00;
            end else if (a == MAXR) begin
                fin     = 1;
                exp_err = 1'b1;
                exp_rd  = 8'h00;
            end
        end

        cmd_log.delete();
        rsp_q.delete();
        attempt    = 0;
        wi         = 0;
        rd_byte    = rb;
        stall_used = 0;
        req_rw     = rw;
        req_dev    = dev;
        req_reg    = rg;
        req_wdata  = wd;
        req_valid  = 1'b1;
        g = 0;
        while (!req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_rw    = 1'($urandom);
        req_dev   = 7'($urandom);
        req_reg   = 8'($urandom);
        req_wdata = 8'($urandom);
        check("busy_not_ready", 32'(req_ready), 32'd0);
        g = 0;
        while (rsp_q.size() == 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check("rsp_count", 32'(rsp_q.size()), 32'd1);
        check("cmd_count", 32'(cmd_log.size()), 32'(exp_q.size()));
        n = (cmd_log.size() < exp_q.size()) ? cmd_log.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("cmd%0d", i), 32'(cmd_log[i]), 32'(exp_q[i]));
        end
        if (rsp_q.size() > 0) begin
            check("rsp_err", 32'(rsp_q[0][8]), 32'(exp_err));
            check("rsp_rdata", 32'(rsp_q[0][7:0]), 32'(exp_rd));
        end
        $display("txn %0d rw=%0d dev=%02h reg=%02h wdata=%02h nack=%0d/%0d/%0d -> cmds=%0d (exp %0d) rsp_err=%0d rsp_rdata=%02h",
                 txn_id, rw, dev, rg, wd, np0, np1, np2, cmd_log.size(), exp_q.size(),
                 exp_err, exp_rd);
        txn_id++;
    endtask

    initial begin
        int g;
        reset            = 1'b0;
        req_valid        = 1'b0;
        req_rw           = 1'b0;
        req_dev          = 7'h00;
        req_reg          = 8'h00;
        req_wdata        = 8'h00;
        rand_stall       = 0;
        rand_spur        = 0;
        hold_read        = 0;
        stall_used       = 0;
        force_stall_byte = -1;
        attempt          = 0;
        wi               = 0;
        rd_byte          = 8'h00;
        txn_id           = 0;
        for (int i = 0; i < 8; i++) nack_pos[i] = -1;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_op", 32'(cmd_op), 32'd0);
        check("rst_cmd_data", 32'(cmd_data), 32'd0);
        check("rst_cmd_nack", 32'(cmd_nack), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Clean write, clean read
        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1, -1);
        run_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, -1, -1, -1);
        // Device address NACK on every attempt
        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 0, 0);
        // Register byte NACK on the first attempt only
        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, -1, -1);
        // Four-cycle stall on WRITE 0x10 with a stray completion inside it
        force_stall_byte = 8'h10;
        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1, -1);
        check("stall_seen", 32'(stall_used), 32'd1);
        force_stall_byte = -1;

        // Reset while the READ completion is outstanding
        hold_read = 1;
        cmd_log.delete();
        rsp_q.delete();
        attempt   = 0;
        wi        = 0;
        rd_byte   = 8'h77;
        req_rw    = 1'b1;
        req_dev   = 7'h50;
        req_reg   = 8'h22;
        req_wdata = 8'h00;
        req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        g = 0;
        while (cmd_log.size() < 6 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("read_reached", 32'(cmd_log.size()), 32'd6);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_cmd_op", 32'(cmd_op), 32'd0);
        check("mid_rst_cmd_data", 32'(cmd_data), 32'd0);
        check("mid_rst_cmd_nack", 32'(cmd_nack), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        hold_read = 0;
        repeat (4) @(negedge clk);
        check("no_stop_after_rst", 32'(cmd_log.size()), 32'd6);
        check("no_rsp_after_rst", 32'(rsp_q.size()), 32'd0);
        $display("txn %0d reset during READ -> cmds=%0d rsp=%0d", txn_id, cmd_log.size(), rsp_q.size());
        txn_id++;
        run_txn(1'b1, 7'h2A, 8'h05, 8'h00, 8'hC3, -1, -1, -1);

        // Randomized traffic with stalls, latency and stray completions
        rand_stall = 1;
        rand_spur  = 1;
        for (int t = 0; t < 40; t++) begin
            for (int a = 0; a < 3; a++) begin
                rp[a] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : -1;
            end
            run_txn(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), rp[0], rp[1], rp[2]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_reg_sequencer.md
I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

Interface
REQ-001 Parameter MAX_RETRY, default 2: number of extra full-transaction attempts after a NACK.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 req_valid  input  1  register-access request present.
REQ-005 req_ready  output  1  sequencer idle, accepts request.
REQ-006 req_rw  input  1  0 = register write, 1 = register read.
REQ-007 req_dev  input  7  7-bit target device address.
REQ-008 req_reg  input  8  target register address.
REQ-009 req_wdata  input  8  write data; ignored for reads.
REQ-010 cmd_valid  output  1  byte-level command to the bit-level I2C engine is valid.
REQ-011 cmd_ready  input  1  engine accepts command.
REQ-012 cmd_op  output  2  00 START, 01 WRITE, 10 READ, 11 STOP.
REQ-013 cmd_data  output  8  byte for WRITE; 0 otherwise.
REQ-014 cmd_nack  output  1  for READ: master sends NACK after byte; 0 for other ops.
REQ-015 done_valid  input  1  one-cycle pulse: outstanding command finished.
REQ-016 done_ack  input  1  slave ACK (1) or NACK (0) for a completed WRITE.
REQ-017 done_data  input  8  byte received for a completed READ.
REQ-018 rsp_valid  output  1  one-cycle pulse: transaction finished.
REQ-019 rsp_rdata  output  8  read byte; 0 for writes and errors.
REQ-020 rsp_err  output  1  1 = NACK persisted through all retries.

Function
REQ-021 States: IDLE, START, DEVW, REG, WDATA, RSTART, DEVR, RDATA, STOP, RESP.
REQ-022 req_ready = 1 only in IDLE; request captured (rw, dev, reg, wdata) on req_valid & req_ready; retry counter cleared; go to START.
REQ-023 Write sequence: START, WRITE {dev,0}, WRITE reg, WRITE wdata, STOP.
REQ-024 Read sequence: START, WRITE {dev,0}, WRITE reg, START (repeated), WRITE {dev,1}, READ with cmd_nack = 1, STOP.
REQ-025 Each state issues exactly one command: cmd_valid rises on state entry and holds cmd_op/cmd_data/cmd_nack stable until cmd_valid & cmd_ready.
REQ-026 After acceptance, cmd_valid = 0 and the state waits for done_valid; advance only on done_valid.
REQ-027 done_valid while no command is outstanding is ignored.
REQ-028 On a WRITE completing with done_ack = 0: skip remaining bytes and go to STOP with a pending-NACK flag.
REQ-029 After STOP done with pending NACK: if retry count < MAX_RETRY, increment the count and return to START (request unchanged); otherwise go to RESP with rsp_err = 1.
REQ-030 RDATA captures done_data into the read register on done_valid.
REQ-031 RESP lasts exactly one cycle: rsp_valid = 1, rsp_rdata/rsp_err valid; next state IDLE.
REQ-032 With cmd_ready = 1 and done_valid returned D cycles after acceptance, a clean write produces 5 commands and a clean read 7; no idle cycles are inserted between done_valid and the next cmd_valid.
REQ-033 A request presented while busy is not captured; the upstream holds it until req_ready.

Reset
REQ-034 While reset = 0: state IDLE, req_ready = 1, cmd_valid = 0, cmd_op = 00, cmd_data = 0, cmd_nack = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, retry count = 0.
REQ-035 Reset mid-transaction aborts immediately: no STOP is issued and no response is produced.

Verification
REQ-036 Write dev 0x50, reg 0x10, data 0xA5, all ACK -> cmds START, WRITE 0xA0, WRITE 0x10, WRITE 0xA5, STOP; rsp_valid pulse, rsp_err = 0, rsp_rdata = 0.
REQ-037 Read dev 0x50, reg 0x22, engine returns 0x3C -> cmds START, WRITE 0xA0, WRITE 0x22, START, WRITE 0xA1, READ nack = 1, STOP; rsp_rdata = 0x3C, rsp_err = 0.
REQ-038 Write with device-address NACK on every attempt, MAX_RETRY = 2 -> three START/WRITE 0xA0/STOP groups, then rsp_err = 1, rsp_rdata = 0.
REQ-039 NACK on reg byte on first attempt only -> one STOP, one retry, second attempt completes; rsp_err = 0.
REQ-040 cmd_ready held 0 for 4 cycles on WRITE 0x10 -> cmd_valid/op/data stable for all 4 cycles; a spurious done_valid in that window is ignored.
REQ-041 reset driven 0 while waiting for the READ done -> outputs at reset values next edge, no STOP or rsp_valid; a new request after release runs normally.
